// File: rtl/id_operand_stage_pkg.sv
// Shared widths, bypass bus layouts and MIPS opcode constants for the decode operand stage.
package id_operand_stage_pkg;

    localparam int unsigned DS_TO_BY_BUS_WD = 12;
    localparam int unsigned BY_TO_DS_BUS_WD = 66;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SWL     = 6'h2a;
    localparam logic [5:0] OP_SW      = 6'h2b;
    localparam logic [5:0] OP_SWR     = 6'h2e;

    typedef struct packed {
        logic        en1;
        logic        en2;
        logic [4:0]  addr1;
        logic [4:0]  addr2;
    } by_req_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data1;
        logic [31:0] data2;
    } by_rsp_t;

endpackage

// File: rtl/id_operand_stage_src_use_dec.sv
// Source-register usage decode: which of rs/rt an instruction actually reads.
module src_use_dec
    import id_operand_stage_pkg::*;
(
    input  logic [31:0] inst,
    output logic        use1,
    output logic        use2
);

    logic [5:0]  opcode;
    logic        unused_inst;

    assign opcode      = inst[31:26];
    assign unused_inst = ^inst[25:0];

    always_comb begin
        use1 = 1'b1;
        use2 = 1'b0;
        case (opcode)
            OP_J, OP_JAL, OP_LUI: use1 = 1'b0;
            default:              use1 = 1'b1;
        endcase
        case (opcode)
            OP_SPECIAL, OP_BEQ, OP_BNE,
            OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: use2 = 1'b1;
            default:                             use2 = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage slot: register read, bypass merge, load-use interlock, valid/allowin handshake.
// Optional macro BYPASS_EN enables the forwarding bus; without it hazards are resolved by stalling.
module id_operand_stage
    import id_operand_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       fs_to_ds_valid,
    input  logic [31:0]                fs_to_ds_pc,
    input  logic [31:0]                fs_to_ds_inst,
    output logic                       ds_allowin,
    output logic                       ds_to_es_valid,
    input  logic                       es_allowin,
    output logic [31:0]                ds_to_es_pc,
    output logic [31:0]                ds_to_es_inst,
    output logic [31:0]                ds_to_es_src1,
    output logic [31:0]                ds_to_es_src2,
    input  logic                       br_flush,
    output logic [4:0]                 rf_raddr1,
    output logic [4:0]                 rf_raddr2,
    input  logic [31:0]                rf_rdata1,
    input  logic [31:0]                rf_rdata2,
    output logic [DS_TO_BY_BUS_WD-1:0] by_req,
    input  logic [BY_TO_DS_BUS_WD-1:0] by_rsp,
    input  logic                       es_valid,
    input  logic                       es_rf_we,
    input  logic                       es_is_load,
    input  logic [4:0]                 es_dest,
    input  logic                       ms_valid,
    input  logic                       ms_rf_we,
    input  logic [4:0]                 ms_dest,
    output logic [31:0]                stall_cnt
);

    logic        ds_valid_q, ds_valid_d;
    logic [31:0] ds_pc_q, ds_pc_d;
    logic [31:0] ds_inst_q, ds_inst_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic        use1, use2;
    logic        en1, en2;
    logic [4:0]  addr1, addr2;
    logic [31:0] rf_src1, rf_src2;
    logic        es_hit, ms_hit;
    logic        stall, ds_ready_go;

    src_use_dec u_src_use_dec (
        .inst (ds_inst_q),
        .use1 (use1),
        .use2 (use2)
    );

    assign addr1     = ds_inst_q[25:21];
    assign addr2     = ds_inst_q[20:16];
    assign rf_raddr1 = addr1;
    assign rf_raddr2 = addr2;

    // $0 never participates in hazards or forwarding and always reads zero.
    assign en1     = use1 & (addr1 != 5'd0);
    assign en2     = use2 & (addr2 != 5'd0);
    assign rf_src1 = (addr1 == 5'd0) ? 32'd0 : rf_rdata1;
    assign rf_src2 = (addr2 == 5'd0) ? 32'd0 : rf_rdata2;

    assign es_hit = (en1 & (es_dest == addr1)) | (en2 & (es_dest == addr2));
    assign ms_hit = (en1 & (ms_dest == addr1)) | (en2 & (ms_dest == addr2));

`ifdef BYPASS_EN
    by_rsp_t     rsp;
    logic        unused_ms;

    assign rsp           = by_rsp;
    assign by_req        = {en1, en2, addr1, addr2};
    assign ds_to_es_src1 = (en1 & rsp.sel[0]) ? rsp.data1 : rf_src1;
    assign ds_to_es_src2 = (en2 & rsp.sel[1]) ? rsp.data2 : rf_src2;
    // Only a load in EXE cannot be forwarded yet; everything else arrives over the bypass.
    assign stall         = es_valid & es_rf_we & es_is_load & es_hit;
    assign unused_ms     = ms_valid ^ ms_rf_we ^ ms_hit;
`else
    logic        unused_bypass;

    assign by_req        = '0;
    assign ds_to_es_src1 = rf_src1;
    assign ds_to_es_src2 = rf_src2;
    assign stall         = (es_valid & es_rf_we & es_hit) | (ms_valid & ms_rf_we & ms_hit);
    assign unused_bypass = ^{by_rsp, es_is_load};
`endif

    assign ds_ready_go    = ~stall;
    assign ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid_q & ds_ready_go & ~br_flush;
    assign ds_to_es_pc    = ds_pc_q;
    assign ds_to_es_inst  = ds_inst_q;
    assign stall_cnt      = stall_cnt_q;

    always_comb begin
        ds_valid_d  = ds_valid_q;
        ds_pc_d     = ds_pc_q;
        ds_inst_d   = ds_inst_q;
        stall_cnt_d = stall_cnt_q;
        // Flush wins over a simultaneous accept; the fetch offer is dropped.
        if (br_flush) begin
            ds_valid_d = 1'b0;
        end else if (ds_allowin) begin
            ds_valid_d = fs_to_ds_valid;
        end
        if (fs_to_ds_valid & ds_allowin & ~br_flush) begin
            ds_pc_d   = fs_to_ds_pc;
            ds_inst_d = fs_to_ds_inst;
        end
        if (ds_valid_q & stall & ~br_flush & ~(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ds_valid_q  <= 1'b0;
            ds_pc_q     <= 32'd0;
            ds_inst_q   <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            ds_valid_q  <= ds_valid_d;
            ds_pc_q     <= ds_pc_d;
            ds_inst_q   <= ds_inst_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios then randomized traffic vs a model.
module tb_id_operand_stage;

    logic        clk;
    logic        resetn;
    logic        fs_to_ds_valid;
    logic [31:0] fs_to_ds_pc;
    logic [31:0] fs_to_ds_inst;
    logic        ds_allowin;
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic [31:0] ds_to_es_pc;
    logic [31:0] ds_to_es_inst;
    logic [31:0] ds_to_es_src1;
    logic [31:0] ds_to_es_src2;
    logic        br_flush;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [11:0] by_req;
    logic [65:0] by_rsp;
    logic        es_valid;
    logic        es_rf_we;
    logic        es_is_load;
    logic [4:0]  es_dest;
    logic        ms_valid;
    logic        ms_rf_we;
    logic [4:0]  ms_dest;
    logic [31:0] stall_cnt;

    logic [1:0]  sel;
    logic [31:0] bd1;
    logic [31:0] bd2;

    int checks;
    int errors;

    // Reference model of the slot contents.
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_cnt;

    assign by_rsp = {sel, bd1, bd2};

    id_operand_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_pc    (fs_to_ds_pc),
        .fs_to_ds_inst  (fs_to_ds_inst),
        .ds_allowin     (ds_allowin),
        .ds_to_es_valid (ds_to_es_valid),
        .es_allowin     (es_allowin),
        .ds_to_es_pc    (ds_to_es_pc),
        .ds_to_es_inst  (ds_to_es_inst),
        .ds_to_es_src1  (ds_to_es_src1),
        .ds_to_es_src2  (ds_to_es_src2),
        .br_flush       (br_flush),
        .rf_raddr1      (rf_raddr1),
        .rf_raddr2      (rf_raddr2),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .by_req         (by_req),
        .by_rsp         (by_rsp),
        .es_valid       (es_valid),
        .es_rf_we       (es_rf_we),
        .es_is_load     (es_is_load),
        .es_dest        (es_dest),
        .ms_valid       (ms_valid),
        .ms_rf_we       (ms_rf_we),
        .ms_dest        (ms_dest),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit reads_rs(input logic [31:0] w);
        return !(w[31:26] inside {6'h02, 6'h03, 6'h0f});
    endfunction

    function automatic bit reads_rt(input logic [31:0] w);
        return w[31:26] inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e};
    endfunction

    function automatic bit model_stall();
        int  rs, rt;
        bit  r1, r2, es_match, ms_match;
        rs = int'(m_inst[25:21]);
        rt = int'(m_inst[20:16]);
        r1 = reads_rs(m_inst) && rs != 0;
        r2 = reads_rt(m_inst) && rt != 0;
        es_match = (r1 && int'(es_dest) == rs) || (r2 && int'(es_dest) == rt);
        ms_match = (r1 && int'(ms_dest) == rs) || (r2 && int'(ms_dest) == rt);
`ifdef BYPASS_EN
        return es_valid && es_rf_we && es_is_load && es_match;
`else
        return (es_valid && es_rf_we && es_match) || (ms_valid && ms_rf_we && ms_match);
`endif
    endfunction

    // Compare every DUT output against the model for the current inputs.
    task automatic check_all(input string ph);
        int          rs, rt;
        bit          r1, r2, st, allow;
        logic [31:0] e1, e2;
        logic [11:0] ereq;
        rs = int'(m_inst[25:21]);
        rt = int'(m_inst[20:16]);
        r1 = reads_rs(m_inst) && rs != 0;
        r2 = reads_rt(m_inst) && rt != 0;
        st = model_stall();
        allow = !m_valid || (!st && es_allowin);
        e1 = (rs == 0) ? 32'd0 : rf_rdata1;
        e2 = (rt == 0) ? 32'd0 : rf_rdata2;
        ereq = 12'd0;
`ifdef BYPASS_EN
        if (r1 && sel[0]) e1 = bd1;
        if (r2 && sel[1]) e2 = bd2;
        ereq = {r1, r2, m_inst[25:21], m_inst[20:16]};
`endif
        chk({ph, "_allowin"}, 32'(ds_allowin), 32'(allow));
        chk({ph, "_valid"}, 32'(ds_to_es_valid), 32'(m_valid && !st && !br_flush));
        chk({ph, "_pc"}, ds_to_es_pc, m_pc);
        chk({ph, "_inst"}, ds_to_es_inst, m_inst);
        chk({ph, "_src1"}, ds_to_es_src1, e1);
        chk({ph, "_src2"}, ds_to_es_src2, e2);
        chk({ph, "_raddr"}, 32'({rf_raddr1, rf_raddr2}), 32'(m_inst[25:16]));
        chk({ph, "_byreq"}, 32'(by_req), 32'(ereq));
        chk({ph, "_stallcnt"}, stall_cnt, m_cnt);
    endtask

    task automatic model_edge();
        bit st, allow;
        st = model_stall();
        allow = !m_valid || (!st && es_allowin);
        if (!resetn) begin
            m_valid = 1'b0;
            m_pc    = 32'd0;
            m_inst  = 32'd0;
            m_cnt   = 32'd0;
        end else begin
            if (m_valid && st && !br_flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (fs_to_ds_valid && allow && !br_flush) begin
                m_pc   = fs_to_ds_pc;
                m_inst = fs_to_ds_inst;
            end
            if (br_flush) m_valid = 1'b0;
            else if (allow) m_valid = fs_to_ds_valid;
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick(input string ph);
        #1;
        check_all(ph);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [5:0]  op;
        w = $urandom;
        case ($urandom_range(0, 9))
            0, 1:    op = 6'h00;
            2:       op = 6'h02;
            3:       op = 6'h03;
            4:       op = 6'h04;
            5:       op = 6'h0f;
            6:       op = 6'h23;
            7:       op = 6'h2b;
            8:       op = 6'h09;
            default: op = 6'($urandom);
        endcase
        w[31:26] = op;
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        m_valid = 1'b0;
        m_pc = 32'd0;
        m_inst = 32'd0;
        m_cnt = 32'd0;
        resetn = 1'b0;
        fs_to_ds_valid = 1'b0;
        fs_to_ds_pc = 32'd0;
        fs_to_ds_inst = 32'd0;
        es_allowin = 1'b1;
        br_flush = 1'b0;
        rf_rdata1 = 32'h1234;
        rf_rdata2 = 32'h5678;
        sel = 2'b00;
        bd1 = 32'd0;
        bd2 = 32'd0;
        es_valid = 1'b0;
        es_rf_we = 1'b0;
        es_is_load = 1'b0;
        es_dest = 5'd0;
        ms_valid = 1'b0;
        ms_rf_we = 1'b0;
        ms_dest = 5'd0;

        @(negedge clk);
        tick("rst0");
        tick("rst1");
        #1;
        chk("rst_allowin", 32'(ds_allowin), 32'd1);
        chk("rst_valid", 32'(ds_to_es_valid), 32'd0);
        chk("rst_src1", ds_to_es_src1, 32'd0);
        chk("rst_src2", ds_to_es_src2, 32'd0);
        chk("rst_byreq", 32'(by_req), 32'd0);
        chk("rst_stallcnt", stall_cnt, 32'd0);

        // Plain issue of ADDU $3,$1,$2.
        resetn = 1'b1;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_pc = 32'h0040_0000;
        fs_to_ds_inst = 32'h0022_1821;
        rf_rdata1 = 32'd5;
        rf_rdata2 = 32'd7;
        tick("issue_in");
        fs_to_ds_valid = 1'b0;
        #1;
        chk("issue_valid", 32'(ds_to_es_valid), 32'd1);
        chk("issue_src1", ds_to_es_src1, 32'd5);
        chk("issue_src2", ds_to_es_src2, 32'd7);
        chk("issue_raddr1", 32'(rf_raddr1), 32'd1);
        chk("issue_pc", ds_to_es_pc, 32'h0040_0000);

        // Forward on src1 only.
        sel = 2'b01;
        bd1 = 32'h0000_00AA;
        bd2 = 32'h0000_00BB;
        #1;
`ifdef BYPASS_EN
        chk("fwd_src1", ds_to_es_src1, 32'h0000_00AA);
        chk("fwd_byreq", 32'(by_req), 32'h0C22);
`else
        chk("fwd_src1", ds_to_es_src1, 32'd5);
        chk("fwd_byreq", 32'(by_req), 32'd0);
`endif
        chk("fwd_src2", ds_to_es_src2, 32'd7);
        tick("fwd");

        // $0 source: never forwarded, never enabled.
        sel = 2'b00;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_pc = 32'h0040_0004;
        fs_to_ds_inst = 32'h0002_1821;
        tick("zero_in");
        fs_to_ds_valid = 1'b0;
        sel = 2'b01;
        #1;
        chk("zero_src1", ds_to_es_src1, 32'd0);
        chk("zero_en1", 32'(by_req[11]), 32'd0);
        tick("zero");

        // Load-use on $4.
        sel = 2'b00;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_pc = 32'h0040_0008;
        fs_to_ds_inst = 32'h0082_1821;
        tick("lu_in");
        fs_to_ds_valid = 1'b0;
        es_valid = 1'b1;
        es_rf_we = 1'b1;
        es_is_load = 1'b1;
        es_dest = 5'd4;
        #1;
        chk("lu_valid", 32'(ds_to_es_valid), 32'd0);
        chk("lu_allowin", 32'(ds_allowin), 32'd0);
        chk("lu_cnt0", stall_cnt, 32'd0);
        tick("lu_stall");
        es_valid = 1'b0;
        es_is_load = 1'b0;
        ms_valid = 1'b1;
        ms_rf_we = 1'b1;
        ms_dest = 5'd4;
        sel = 2'b01;
        bd1 = 32'h0000_BEEF;
        rf_rdata1 = 32'h0000_0044;
        #1;
        chk("lu_cnt1", stall_cnt, 32'd1);
`ifdef BYPASS_EN
        chk("lu_release", 32'(ds_to_es_valid), 32'd1);
        chk("lu_fwd", ds_to_es_src1, 32'h0000_BEEF);
        tick("lu_rel");
`else
        chk("nb_ms_stall", 32'(ds_to_es_valid), 32'd0);
        tick("nb_ms");
        ms_valid = 1'b0;
        #1;
        chk("nb_release", 32'(ds_to_es_valid), 32'd1);
        chk("nb_src1", ds_to_es_src1, 32'h0000_0044);
        chk("nb_cnt2", stall_cnt, 32'd2);
        tick("nb_rel");
`endif
        ms_valid = 1'b0;
        sel = 2'b00;

        // Flush together with a fetch offer.
        fs_to_ds_valid = 1'b1;
        br_flush = 1'b1;
        fs_to_ds_pc = 32'h0000_0100;
        fs_to_ds_inst = 32'h0022_1821;
        tick("fl_in");
        fs_to_ds_valid = 1'b0;
        br_flush = 1'b0;
        #1;
        chk("fl_valid", 32'(ds_to_es_valid), 32'd0);
        chk("fl_allowin", 32'(ds_allowin), 32'd1);
        tick("fl");

        // Backpressure holds the slot.
        fs_to_ds_valid = 1'b1;
        fs_to_ds_pc = 32'h0000_0200;
        es_allowin = 1'b0;
        tick("bp_in");
        fs_to_ds_pc = 32'h0000_0300;
        #1;
        chk("bp_allowin", 32'(ds_allowin), 32'd0);
        tick("bp_hold");
        #1;
        chk("bp_pc", ds_to_es_pc, 32'h0000_0200);
        es_allowin = 1'b1;
        fs_to_ds_valid = 1'b0;
        tick("bp_rel");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            resetn = ($urandom_range(0, 40) != 0);
            fs_to_ds_valid = ($urandom_range(0, 9) < 7);
            fs_to_ds_pc = $urandom;
            fs_to_ds_inst = rand_inst();
            es_allowin = ($urandom_range(0, 3) != 0);
            br_flush = ($urandom_range(0, 9) == 0);
            rf_rdata1 = $urandom;
            rf_rdata2 = $urandom;
            sel = 2'($urandom);
            bd1 = $urandom;
            bd2 = $urandom;
            es_valid = 1'($urandom);
            es_rf_we = 1'($urandom);
            es_is_load = 1'($urandom);
            es_dest = 5'($urandom_range(0, 7));
            ms_valid = 1'($urandom);
            ms_rf_we = 1'($urandom);
            ms_dest = 5'($urandom_range(0, 7));
            tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
